wash_cycle_sequencer: RTL
=========================

Name: wash_cycle_sequencer

Overview:
Parametrised successor to the single-program washer FSM. Sequences fill, wash, drain, N rinse passes and spin, with selectable wash program, door-open pause/resume, abort with safe drain, and fill/drain timeout fault. Sits between the panel inputs and the valve/motor actuator drivers in the appliance control subsystem.

Parameters:
CNT_W, 8, width of the phase timer and the timeout counter
WASH_T_QUICK, 10, wash duration in cycles, mode 2'b01
WASH_T_NORMAL, 20, wash duration in cycles, mode 2'b00 and reserved 2'b11
WASH_T_HEAVY, 40, wash duration in cycles, mode 2'b10
RINSE_T, 8, agitation cycles per rinse pass
SPIN_T, 16, spin duration in cycles
N_RINSE, 2, number of rinse passes (>=1)
TMO_T, 60, maximum cycles allowed in any fill or drain state

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin cycle; sampled only in IDLE
abort  in  1  level; cancel cycle, drain, return to IDLE
mode  in  2  program select; latched on accepted start
door_closed  in  1  door interlock
water_full  in  1  level sensor, tub full
water_empty  in  1  level sensor, tub empty
water_valve  out  1  fill valve open
drain_valve  out  1  drain valve open
motor  out  2  00 off, 01 wash, 11 spin
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
fault  out  1  high while in FAULT
state_o  out  4  current state code
rinse_cnt  out  CNT_W  completed rinse passes

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; timers, rinse_cnt, saved-state register cleared. Released mid-cycle -> restarts in IDLE; no resume.
- Outputs: Moore decode of the registered state, valid the cycle the state is entered.
- State codes: IDLE 0, FILL 1, WASH 2, DRAIN 3, R_FILL 4, RINSE 5, R_DRAIN 6, SPIN 7, DONE 8, PAUSE 9, ABORT_DRAIN 10, FAULT 11.
- Actuators: FILL/R_FILL water_valve=1; WASH/RINSE motor=01; DRAIN/R_DRAIN/ABORT_DRAIN drain_valve=1; SPIN motor=11, drain_valve=1; all others all off.
- IDLE: start & door_closed -> FILL; latch mode; clear rinse_cnt. start with door open is ignored.
- FILL/R_FILL: exit on first cycle water_full=1 -> WASH/RINSE, timer=0. Timeout counter increments each cycle in state; reaching TMO_T-1 without the sensor -> FAULT.
- WASH: exactly WASH_T(mode) cycles (timer 0..T-1), then DRAIN. RINSE: exactly RINSE_T cycles, then R_DRAIN.
- DRAIN: water_empty -> R_FILL. R_DRAIN: water_empty -> rinse_cnt+1; if the new value == N_RINSE -> SPIN, else R_FILL. Both use the same TMO_T timeout -> FAULT.
- SPIN: exactly SPIN_T cycles -> DONE. DONE: done=1 for one cycle -> IDLE.
- PAUSE: door_closed=0 in FILL, WASH, R_FILL, RINSE or SPIN -> PAUSE. Save the originating state; freeze timer and timeout counter; all actuators off. door_closed=1 -> return to the saved state, timer continuing from the held value. Door open in drain states is ignored; draining continues.
- ABORT: abort=1 in any busy state except FAULT and ABORT_DRAIN -> ABORT_DRAIN. Exit on water_empty -> IDLE, no done. Subject to TMO_T -> FAULT.
- FAULT: all actuators off, fault=1. Left only via abort=1 -> IDLE.
- Priority per cycle: abort > door-open pause > timeout > normal transition.
- Timers saturate and never wrap. Parameters must fit in CNT_W. Timeout counter clears on every state entry except return from PAUSE.

Test Plan:
- Normal program: start=1, mode=00, sensors respond 3 cycles after valve opens -> WASH held 20 cycles, 2 rinse passes of 8 cycles, SPIN 16 cycles with motor=11, done pulses once, rinse_cnt=2, then IDLE.
- Mode select: mode=01 -> WASH 10 cycles; mode=10 -> 40 cycles; mode=11 -> 20 cycles. Changing mode mid-cycle has no effect.
- Pause: door_closed=0 at WASH timer=7 for 5 cycles -> PAUSE, motor=00, timer held. On close, WASH resumes; total WASH cycles=20.
- Fill timeout: water_full held 0 -> FAULT after exactly 60 FILL cycles, fault=1, valves closed. abort=1 -> IDLE, fault=0.
- Abort: abort=1 during RINSE -> ABORT_DRAIN, drain_valve=1; water_empty=1 -> IDLE, done never asserted.
- Async reset: rst=0 mid-SPIN -> all outputs 0 immediately without a clock edge; after release, state_o=0 and start is required to run again.

Source files
------------

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: fill, wash, drain, N rinse passes and spin,
// with door pause/resume, abort-to-drain and fill/drain timeout fault.
module wash_cycle_sequencer #(
    parameter int CNT_W         = 8,
    parameter int WASH_T_QUICK  = 10,
    parameter int WASH_T_NORMAL = 20,
    parameter int WASH_T_HEAVY  = 40,
    parameter int RINSE_T       = 8,
    parameter int SPIN_T        = 16,
    parameter int N_RINSE       = 2,
    parameter int TMO_T         = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             door_closed,
    input  logic             water_full,
    input  logic             water_empty,
    output logic             water_valve,
    output logic             drain_valve,
    output logic [1:0]       motor,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] rinse_cnt
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL        = 4'd1,
        WASH        = 4'd2,
        DRAIN       = 4'd3,
        R_FILL      = 4'd4,
        RINSE       = 4'd5,
        R_DRAIN     = 4'd6,
        SPIN        = 4'd7,
        DONE        = 4'd8,
        PAUSE       = 4'd9,
        ABORT_DRAIN = 4'd10,
        FAULT       = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT        = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] QUICK_LAST = CNT_W'(WASH_T_QUICK - 1);
    localparam logic [CNT_W-1:0] NORM_LAST  = CNT_W'(WASH_T_NORMAL - 1);
    localparam logic [CNT_W-1:0] HEAVY_LAST = CNT_W'(WASH_T_HEAVY - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_T - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_T - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_T - 1);
    localparam logic [CNT_W-1:0] RINSE_N    = CNT_W'(N_RINSE);

    state_t           state, next, saved;
    logic [CNT_W-1:0] timer, tmo;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] wash_last;
    logic [CNT_W-1:0] rinse_nxt;
    logic             accept, rinse_inc;
    logic             pausable, tmo_state;
    logic             hold_cnt, clr_cnt;

    always_comb begin
        case (mode_q)
            2'b01:   wash_last = QUICK_LAST;
            2'b10:   wash_last = HEAVY_LAST;
            default: wash_last = NORM_LAST;
        endcase
    end

    assign rinse_nxt = (rinse_cnt == SAT) ? rinse_cnt : rinse_cnt + ONE;
    assign pausable  = state inside {FILL, WASH, R_FILL, RINSE, SPIN};
    assign tmo_state = state inside {FILL, R_FILL, DRAIN, R_DRAIN, ABORT_DRAIN};

    always_comb begin
        next      = state;
        accept    = 1'b0;
        rinse_inc = 1'b0;
        if (abort && state != IDLE && state != FAULT && state != ABORT_DRAIN) begin
            next = ABORT_DRAIN;
        end else if (!door_closed && pausable) begin
            next = PAUSE;
        end else if (tmo_state && tmo >= TMO_LAST) begin
            next = FAULT;
        end else begin
            case (state)
                IDLE:        if (start && door_closed) begin
                                 next   = FILL;
                                 accept = 1'b1;
                             end
                FILL:        if (water_full) next = WASH;
                WASH:        if (timer >= wash_last) next = DRAIN;
                DRAIN:       if (water_empty) next = R_FILL;
                R_FILL:      if (water_full) next = RINSE;
                RINSE:       if (timer >= RINSE_LAST) next = R_DRAIN;
                R_DRAIN:     if (water_empty) begin
                                 rinse_inc = 1'b1;
                                 next      = (rinse_nxt == RINSE_N) ? SPIN : R_FILL;
                             end
                SPIN:        if (timer >= SPIN_LAST) next = DONE;
                DONE:        next = IDLE;
                PAUSE:       if (door_closed) next = saved;
                ABORT_DRAIN: if (water_empty) next = IDLE;
                FAULT:       if (abort) next = IDLE;
                default:     next = IDLE;
            endcase
        end
    end

    // Counters keep running on the cycle that enters PAUSE and are held while
    // paused, so a resumed phase still totals its programmed length.
    assign hold_cnt = (state == PAUSE) && (next == PAUSE || next == saved);
    assign clr_cnt  = !hold_cnt && (next != state) && (next != PAUSE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            saved     <= IDLE;
            timer     <= '0;
            tmo       <= '0;
            mode_q    <= 2'b00;
            rinse_cnt <= '0;
        end else begin
            state <= next;
            if (next == PAUSE && state != PAUSE) saved <= state;
            if (accept) begin
                mode_q    <= mode;
                rinse_cnt <= '0;
            end else if (rinse_inc) begin
                rinse_cnt <= rinse_nxt;
            end
            if (clr_cnt) begin
                timer <= '0;
                tmo   <= '0;
            end else if (!hold_cnt) begin
                timer <= (timer == SAT) ? timer : timer + ONE;
                tmo   <= (tmo == SAT) ? tmo : tmo + ONE;
            end
        end
    end

    always_comb begin
        water_valve = 1'b0;
        drain_valve = 1'b0;
        motor       = 2'b00;
        case (state)
            FILL, R_FILL:                water_valve = 1'b1;
            WASH, RINSE:                 motor       = 2'b01;
            DRAIN, R_DRAIN, ABORT_DRAIN: drain_valve = 1'b1;
            SPIN: begin
                motor       = 2'b11;
                drain_valve = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign fault   = (state == FAULT);
    assign state_o = state;

endmodule
